// File: rtl/truth_table_pkg.sv
// truth_table_capture shared types and constants.
// State encoding, default sizing and table-width helper.
package truth_table_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SAMP,
    DONE
  } tt_state_t;

  localparam int unsigned N_IN_DEF   = 5;
  localparam int unsigned SETTLE_DEF = 1;

  function automatic int unsigned tt_width(
    input int unsigned n
  );
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Settle-time down-counter for truth_table_capture.
// expired marks the last settle cycle of a pattern.
module tt_settle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       expired
);

  logic [3:0] cnt;

  // Load on WAIT entry, then count down to zero and rest there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (clear) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // The count reaches zero at the end of this cycle.
  assign expired = (cnt == 4'd1);

endmodule

// File: rtl/truth_table_capture.sv
// Exhaustive sweep of a small combinational function.
// Drives every pattern, samples f_in, compares to a table.
module truth_table_capture
  import truth_table_pkg::*;
#(
  parameter int unsigned N_IN   = N_IN_DEF,
  parameter int unsigned SETTLE = SETTLE_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic [tt_width(N_IN)-1:0]   expected,
  output logic [N_IN-1:0]             pattern,
  input  logic                        f_in,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [tt_width(N_IN)-1:0]   captured,
  output logic [N_IN:0]               mismatch_count,
  output logic [N_IN-1:0]             first_fail,
  output logic                        fail_valid
);

  localparam int unsigned W = tt_width(N_IN);
  localparam logic [N_IN-1:0] LAST = '1;
  localparam logic [3:0] SETTLE_V = 4'(SETTLE);

  tt_state_t state;
  tt_state_t nxt;

  logic [W-1:0] exp_q;
  logic         expired;
  logic         last;
  logic         mis;
  logic         accept;
  logic         samp;
  logic         tmr_load;
  logic         tmr_clear;

  assign last = (pattern == LAST);
  assign mis  = (f_in != exp_q[pattern]);

  tt_settle_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (tmr_clear),
    .load     (tmr_load),
    .load_val (SETTLE_V),
    .expired  (expired)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // Next state, status outputs and datapath strobes.
  always_comb begin
    nxt       = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    samp      = 1'b0;
    tmr_clear = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          nxt    = (SETTLE == 0) ? SAMP : WAIT;
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (abort) begin
          nxt       = IDLE;
          tmr_clear = 1'b1;
        end else if (expired) begin
          nxt = SAMP;
        end
      end
      SAMP: begin
        busy = 1'b1;
        if (abort) begin
          nxt       = IDLE;
          tmr_clear = 1'b1;
        end else begin
          samp = 1'b1;
          if (last) begin
            nxt = DONE;
          end else begin
            nxt = (SETTLE == 0) ? SAMP : WAIT;
          end
        end
      end
      DONE: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
    tmr_load = (nxt == WAIT) && (state != WAIT);
  end

  // Sweep datapath: clear on start, record each sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern        <= '0;
      captured       <= '0;
      mismatch_count <= '0;
      first_fail     <= '0;
      fail_valid     <= 1'b0;
      pass           <= 1'b0;
      exp_q          <= '0;
    end else begin
      if (accept) begin
        pattern        <= '0;
        captured       <= '0;
        mismatch_count <= '0;
        first_fail     <= '0;
        fail_valid     <= 1'b0;
        pass           <= 1'b0;
        exp_q          <= expected;
      end
      if (samp) begin
        captured[pattern] <= f_in;
        if (mis) begin
          mismatch_count <= mismatch_count + 1'b1;
          if (!fail_valid) begin
            first_fail <= pattern;
            fail_valid <= 1'b1;
          end
        end
        if (last) begin
          pass <= (mismatch_count == '0) && !mis;
        end else begin
          pattern <= pattern + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_truth_table_capture.sv
// Bench for truth_table_capture: timing-formula model
// plus directed sweeps with literal expectations.
module tb_truth_table_capture;

  typedef struct packed {
    logic [4:0]  pattern;
    logic        busy;
    logic        done;
    logic        pass;
    logic [31:0] captured;
    logic [5:0]  mcount;
    logic [4:0]  ff;
    logic        fv;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // per-instance model control: 0 off, 1 sweep, 2 all zero
  int mode[2];
  int e0[2];
  int fsel[2];
  logic [31:0] mexp[2];

  logic start0 = 1'b0, start1 = 1'b0;
  logic abort0 = 1'b0, abort1 = 1'b0;
  logic [31:0] exp0 = '0, exp1 = '0;
  logic [4:0] pat0, pat1, ff0, ff1;
  logic f0, f1;
  logic busy0, busy1, done0, done1;
  logic pass0, pass1, fv0, fv1;
  logic [31:0] cap0, cap1;
  logic [5:0] mc0, mc1;
  obs_t o0, o1;

  function automatic logic ffun(int sel, int p);
    case (sel)
      0: return p[0];
      1: return 1'b0;
      2: return p == 19;
      3: return p[4];
      default: return 1'b0;
    endcase
  endfunction

  assign f0 = ffun(fsel[0], int'(pat0));
  assign f1 = ffun(fsel[1], int'(pat1));

  assign o0 = {pat0, busy0, done0, pass0, cap0, mc0, ff0, fv0};
  assign o1 = {pat1, busy1, done1, pass1, cap1, mc1, ff1, fv1};

  truth_table_capture #(.N_IN(5), .SETTLE(0)) dut0 (
    .clk            (clk),
    .rst            (rst),
    .start          (start0),
    .abort          (abort0),
    .expected       (exp0),
    .pattern        (pat0),
    .f_in           (f0),
    .busy           (busy0),
    .done           (done0),
    .pass           (pass0),
    .captured       (cap0),
    .mismatch_count (mc0),
    .first_fail     (ff0),
    .fail_valid     (fv0)
  );

  truth_table_capture #(.N_IN(5), .SETTLE(1)) dut1 (
    .clk            (clk),
    .rst            (rst),
    .start          (start1),
    .abort          (abort1),
    .expected       (exp1),
    .pattern        (pat1),
    .f_in           (f1),
    .busy           (busy1),
    .done           (done1),
    .pass           (pass1),
    .captured       (cap1),
    .mismatch_count (mc1),
    .first_fail     (ff1),
    .fail_valid     (fv1)
  );

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exv);
    tests++;
    if (act !== exv) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exv);
    end
  endtask

  // Outputs t cycles after the accepting edge, from the
  // sweep timing rule: one pattern per (s+1) cycles.
  function automatic obs_t model(int s, int t, logic [31:0] ex, int fs);
    obs_t o;
    int per, n, cnt, first;
    logic [31:0] cap;
    per = s + 1;
    n = t / per;
    if (n > 32) n = 32;
    cap = '0;
    cnt = 0;
    first = -1;
    for (int i = 0; i < n; i++) begin
      cap[i] = ffun(fs, i);
      if (cap[i] != ex[i]) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    o.pattern  = 5'((t / per > 31) ? 31 : t / per);
    o.busy     = t < 32 * per;
    o.done     = t == 32 * per;
    o.pass     = (t >= 32 * per) && (cnt == 0);
    o.captured = cap;
    o.mcount   = 6'(cnt);
    o.ff       = (first < 0) ? 5'd0 : 5'(first);
    o.fv       = cnt != 0;
    return o;
  endfunction

  // Compare both instances against the model every cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      obs_t o;
      int t;
      o = (i == 0) ? o0 : o1;
      t = cyc - e0[i];
      if (mode[i] == 2) begin
        chk($sformatf("zero%0d c=%0d", i, cyc), 64'(o), 64'(0));
      end else if (mode[i] == 1 && t >= 0) begin
        chk($sformatf("model%0d t=%0d", i, t), 64'(o),
            64'(model(1 - (i == 0 ? 1 : 0), t, mexp[i], fsel[i])));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(int i, int fs, logic [31:0] ex);
    fsel[i] = fs;
    mexp[i] = ex;
    e0[i] = cyc + 1;
    mode[i] = 1;
    if (i == 0) begin
      exp0 = ex;
      start0 = 1'b1;
    end else begin
      exp1 = ex;
      start1 = 1'b1;
    end
    tick();
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_done(int i, int lat, string nm);
    obs_t o;
    int got;
    o = '0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      o = (i == 0) ? o0 : o1;
      if (o.done) break;
    end
    got = o.done ? cyc - e0[i] : -1;
    chk(nm, 64'(got), 64'(lat));
  endtask

  initial begin
    int b;
    mode[0] = 2;
    mode[1] = 2;
    e0[0] = 0;
    e0[1] = 0;
    fsel[0] = 1;
    fsel[1] = 1;
    mexp[0] = '0;
    mexp[1] = '0;
    #1;
    chk("rst cap", 64'(cap1), 64'(0));
    chk("rst busy", 64'(busy1), 64'(0));
    chk("rst pat", 64'(pat1), 64'(0));
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    // sweep 1: f = pattern[0], matches AAAAAAAA
    go(1, 0, 32'hAAAAAAAA);
    chk("t1 busy", 64'(busy1), 64'(1));
    wait_done(1, 64, "t1 done lat");
    chk("t1 cap", 64'(cap1), 64'(32'hAAAAAAAA));
    chk("t1 pass", 64'(pass1), 64'(1));
    chk("t1 cnt", 64'(mc1), 64'(0));
    chk("t1 fv", 64'(fv1), 64'(0));
    repeat (3) tick();

    // sweep 2: f tied low vs all ones; start at E0+10 ignored
    go(1, 1, 32'hFFFFFFFF);
    b = e0[1];
    while (cyc < b + 9) tick();
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    wait_done(1, 64, "t2 done lat");
    chk("t2 cap", 64'(cap1), 64'(0));
    chk("t2 cnt", 64'(mc1), 64'(32));
    chk("t2 ff", 64'(ff1), 64'(0));
    chk("t2 fv", 64'(fv1), 64'(1));
    chk("t2 pass", 64'(pass1), 64'(0));
    tick();

    // sweep 3: single hot pattern 19
    go(1, 2, 32'h0);
    wait_done(1, 64, "t3 done lat");
    chk("t3 cnt", 64'(mc1), 64'(1));
    chk("t3 ff", 64'(ff1), 64'(19));
    chk("t3 cap", 64'(cap1), 64'(32'h00080000));
    chk("t3 pass", 64'(pass1), 64'(0));
    repeat (2) tick();

    // sweep 4: zero settle, f = pattern[4]
    go(0, 3, 32'hFFFF0000);
    chk("t4 pat0", 64'(pat0), 64'(0));
    tick();
    chk("t4 pat1", 64'(pat0), 64'(1));
    tick();
    chk("t4 pat2", 64'(pat0), 64'(2));
    wait_done(0, 32, "t4 done lat");
    chk("t4 cap", 64'(cap0), 64'(32'hFFFF0000));
    chk("t4 pass", 64'(pass0), 64'(1));
    repeat (2) tick();

    // sweep 5: abort at E0+20, restart at E0+23
    go(1, 0, 32'hAAAAAAAA);
    b = e0[1];
    while (cyc < b + 19) tick();
    abort1 = 1'b1;
    mode[1] = 0;
    tick();
    abort1 = 1'b0;
    chk("t5 busy", 64'(busy1), 64'(0));
    chk("t5 done", 64'(done1), 64'(0));
    chk("t5 pass", 64'(pass1), 64'(0));
    while (cyc < b + 22) begin
      tick();
      chk("t5 nodone", 64'(done1), 64'(0));
    end
    go(1, 0, 32'hAAAAAAAA);
    chk("t5 e0", 64'(e0[1] - b), 64'(23));
    wait_done(1, 64, "t5 done lat");
    chk("t5 pass2", 64'(pass1), 64'(1));
    repeat (2) tick();

    // sweep 6: reset at E0+30 clears everything at once
    go(1, 0, 32'hAAAAAAAA);
    b = e0[1];
    while (cyc < b + 30) tick();
    mode[0] = 2;
    mode[1] = 2;
    rst = 1'b1;
    #1;
    chk("t6 o1", 64'(o1), 64'(0));
    chk("t6 o0", 64'(o0), 64'(0));
    tick();
    #4;
    rst = 1'b0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
